// File: rtl/knn_glb_pkg.sv
// Shared widths and grant encoding for the KNN GLB port.
package knn_glb_pkg;

  localparam int SRAM_WIDTH_DEF = 256;
  localparam int IDX_WIDTH_DEF  = 10;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/knn_glb_port_fifo.sv
// glb_rsp_fifo: read-return FIFO with flush; holds words the KNN has not yet taken.
module glb_rsp_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdat,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdat,
  output logic [OCC_W-1:0] o_occ,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]        r_occ;
  logic                    w_full, w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign o_empty = (r_occ == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_rdat  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdat;
  end

  // The upstream credit check guarantees a free slot for every push.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr) assert (!(i_push && w_full && !i_pop));
  end

endmodule

// File: rtl/knn_glb_port.sv
// GLB responder for the KNN engine: arbitrates coordinate reads against map writes on one SRAM bank.
module knn_glb_port
  import knn_glb_pkg::*;
#(
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CCUGLB_Clr,
  input  logic [ADDR_WIDTH-1:0] CCUGLB_CrdBase,
  input  logic [ADDR_WIDTH-1:0] CCUGLB_MapBase,
  input  logic [ADDR_WIDTH-1:0] CCUGLB_MapWords,
  input  logic [IDX_WIDTH-1:0]  KNNGLB_CrdIdxAddr,
  input  logic                  KNNGLB_CrdIdxAddrVld,
  output logic                  GLBKNN_CrdIdxAddrRdy,
  output logic [SRAM_WIDTH-1:0] GLBKNN_CrdIdx,
  output logic                  GLBKNN_CrdIdxVld,
  input  logic                  KNNGLB_CrdIdxRdy,
  input  logic [SRAM_WIDTH-1:0] KNNGLB_Map,
  input  logic                  KNNGLB_MapVld,
  output logic                  GLBKNN_MapRdy,
  output logic [ADDR_WIDTH-1:0] GLBSRAM_Addr,
  output logic                  GLBSRAM_En,
  output logic                  GLBSRAM_We,
  output logic [SRAM_WIDTH-1:0] GLBSRAM_WDat,
  input  logic [SRAM_WIDTH-1:0] SRAMGLB_RDat,
  output logic [ADDR_WIDTH-1:0] GLBCCU_MapWrCnt
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic                  r_inflight;
  grant_e                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_wr_cnt, r_addr_last;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_empty, w_rd_ok, w_rd_req, w_wr_req;
  logic                  w_grant_rd, w_grant_wr;
  logic [ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;

  // Outstanding = words in the FIFO plus the one read whose data is still on the SRAM bus.
  assign w_rd_ok  = (int'(w_occ) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_rd_req = rst_n & ~CCUGLB_Clr & KNNGLB_CrdIdxAddrVld & w_rd_ok;
  assign w_wr_req = rst_n & ~CCUGLB_Clr & KNNGLB_MapVld;

  always_comb begin
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    if (w_rd_req && w_wr_req) begin
      if (r_last_grant == GRANT_WR) w_grant_rd = 1'b1;
      else                          w_grant_wr = 1'b1;
    end else if (w_rd_req) begin
      w_grant_rd = 1'b1;
    end else if (w_wr_req) begin
      w_grant_wr = 1'b1;
    end
  end

  assign w_rd_addr = CCUGLB_CrdBase + ADDR_WIDTH'(KNNGLB_CrdIdxAddr);
  assign w_wr_addr = CCUGLB_MapBase + r_wr_ptr;

  assign GLBKNN_CrdIdxAddrRdy = w_grant_rd;
  assign GLBKNN_MapRdy        = w_grant_wr & ~CCUGLB_Clr;
  assign GLBSRAM_En           = w_grant_rd | w_grant_wr;
  assign GLBSRAM_We           = w_grant_wr;
  assign GLBSRAM_WDat         = KNNGLB_Map;
  assign GLBSRAM_Addr         = w_grant_rd ? w_rd_addr :
                                w_grant_wr ? w_wr_addr : r_addr_last;
  assign GLBCCU_MapWrCnt      = r_wr_cnt;
  assign GLBKNN_CrdIdxVld     = ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_last_grant <= GRANT_WR;
      r_wr_ptr     <= '0;
      r_wr_cnt     <= '0;
      r_addr_last  <= '0;
    end else begin
      r_inflight <= w_grant_rd;
      if (w_grant_rd)      r_last_grant <= GRANT_RD;
      else if (w_grant_wr) r_last_grant <= GRANT_WR;
      if (GLBSRAM_En) r_addr_last <= GLBSRAM_Addr;
      if (CCUGLB_Clr) begin
        r_wr_ptr <= '0;
        r_wr_cnt <= '0;
      end else if (w_grant_wr) begin
        r_wr_ptr <= (r_wr_ptr >= CCUGLB_MapWords - ADDR_WIDTH'(1)) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // A read in flight during Clr is dropped here; the FIFO flush covers stored words.
  glb_rsp_fifo #(
    .W     (SRAM_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .OCC_W (OCC_W)
  ) u_rsp_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (CCUGLB_Clr),
    .i_push  (r_inflight & ~CCUGLB_Clr),
    .i_wdat  (SRAMGLB_RDat),
    .i_pop   (GLBKNN_CrdIdxVld & KNNGLB_CrdIdxRdy),
    .o_rdat  (GLBKNN_CrdIdx),
    .o_occ   (w_occ),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_knn_glb_port.sv
// Randomized bench for knn_glb_port against a transaction-level model (outstanding queue + reference memory).
module tb_knn_glb_port;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         CCUGLB_Clr = 1'b0;
  logic [11:0]  CCUGLB_CrdBase = '0, CCUGLB_MapBase = '0, CCUGLB_MapWords = 12'd16;
  logic [9:0]   KNNGLB_CrdIdxAddr = '0;
  logic         KNNGLB_CrdIdxAddrVld = 1'b0;
  logic         GLBKNN_CrdIdxAddrRdy;
  logic [255:0] GLBKNN_CrdIdx;
  logic         GLBKNN_CrdIdxVld;
  logic         KNNGLB_CrdIdxRdy = 1'b0;
  logic [255:0] KNNGLB_Map = '0;
  logic         KNNGLB_MapVld = 1'b0;
  logic         GLBKNN_MapRdy;
  logic [11:0]  GLBSRAM_Addr;
  logic         GLBSRAM_En, GLBSRAM_We;
  logic [255:0] GLBSRAM_WDat;
  logic [255:0] SRAMGLB_RDat = '0;
  logic [11:0]  GLBCCU_MapWrCnt;

  knn_glb_port dut (
    .clk(clk), .rst_n(rst_n), .CCUGLB_Clr(CCUGLB_Clr),
    .CCUGLB_CrdBase(CCUGLB_CrdBase), .CCUGLB_MapBase(CCUGLB_MapBase), .CCUGLB_MapWords(CCUGLB_MapWords),
    .KNNGLB_CrdIdxAddr(KNNGLB_CrdIdxAddr), .KNNGLB_CrdIdxAddrVld(KNNGLB_CrdIdxAddrVld),
    .GLBKNN_CrdIdxAddrRdy(GLBKNN_CrdIdxAddrRdy), .GLBKNN_CrdIdx(GLBKNN_CrdIdx),
    .GLBKNN_CrdIdxVld(GLBKNN_CrdIdxVld), .KNNGLB_CrdIdxRdy(KNNGLB_CrdIdxRdy),
    .KNNGLB_Map(KNNGLB_Map), .KNNGLB_MapVld(KNNGLB_MapVld), .GLBKNN_MapRdy(GLBKNN_MapRdy),
    .GLBSRAM_Addr(GLBSRAM_Addr), .GLBSRAM_En(GLBSRAM_En), .GLBSRAM_We(GLBSRAM_We),
    .GLBSRAM_WDat(GLBSRAM_WDat), .SRAMGLB_RDat(SRAMGLB_RDat), .GLBCCU_MapWrCnt(GLBCCU_MapWrCnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, 1-cycle read latency.
  logic [255:0] sram [4096];
  always @(posedge clk) begin
    if (GLBSRAM_En) begin
      if (GLBSRAM_We) sram[GLBSRAM_Addr] <= GLBSRAM_WDat;
      else            SRAMGLB_RDat <= sram[GLBSRAM_Addr];
    end
  end

  // Reference model state
  typedef struct { logic [255:0] d; int t; } rd_t;
  rd_t          exp_q[$];
  logic [255:0] ref_mem [4096];
  int           cyc = 0, m_ptr = 0, m_cnt = 0;
  logic         m_last_rd = 1'b0;
  logic [11:0]  m_last_addr = '0;

  int n_chk = 0, n_err = 0;
  logic        g_ardy, g_mrdy, g_vld;
  logic [11:0] g_addr;
  int          g_cyc;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step(input logic rst, input logic av, input logic [9:0] a, input logic mv,
                      input logic [255:0] md, input logic rdy, input logic clr);
    logic        e_rd, e_wr, rd_el, e_vld, pop;
    logic [11:0] e_addr;
    rst_n = rst; KNNGLB_CrdIdxAddrVld = av; KNNGLB_CrdIdxAddr = a;
    KNNGLB_MapVld = mv; KNNGLB_Map = md; KNNGLB_CrdIdxRdy = rdy; CCUGLB_Clr = clr;
    #1;
    g_ardy = GLBKNN_CrdIdxAddrRdy; g_mrdy = GLBKNN_MapRdy; g_vld = GLBKNN_CrdIdxVld;
    g_addr = GLBSRAM_Addr; g_cyc = cyc;
    e_rd = 1'b0; e_wr = 1'b0; pop = 1'b0; e_addr = m_last_addr;
    if (rst) begin
      rd_el = av && (exp_q.size() < DEPTH) && !clr;
      if (rd_el && mv && !clr) begin
        if (m_last_rd) e_wr = 1'b1; else e_rd = 1'b1;
      end else if (rd_el) e_rd = 1'b1;
      else if (mv && !clr) e_wr = 1'b1;
      if (e_rd)      e_addr = 12'(int'(CCUGLB_CrdBase) + int'(a));
      else if (e_wr) e_addr = 12'(int'(CCUGLB_MapBase) + m_ptr);
      e_vld = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
      chk("addr_rdy", g_ardy, e_rd);
      chk("map_rdy", g_mrdy, e_wr);
      chk("sram_en", GLBSRAM_En, e_rd | e_wr);
      chk("sram_addr", g_addr, e_addr);
      if (e_wr) begin
        chk("sram_we", GLBSRAM_We, 1'b1);
        chk("sram_wdat", GLBSRAM_WDat, md);
      end
      if (e_rd) chk("sram_we_rd", GLBSRAM_We, 1'b0);
      chk("crd_vld", g_vld, e_vld);
      if (e_vld) chk("crd_data", GLBKNN_CrdIdx, exp_q[0].d);
      chk("wr_cnt", GLBCCU_MapWrCnt, 12'(m_cnt));
      pop = e_vld && rdy;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_q.delete(); m_ptr = 0; m_cnt = 0; m_last_rd = 1'b0; m_last_addr = '0;
    end else if (clr) begin
      exp_q.delete(); m_ptr = 0; m_cnt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (e_rd) exp_q.push_back('{d: ref_mem[e_addr], t: cyc});
      if (e_wr) begin
        ref_mem[e_addr] = md;
        m_ptr = (m_ptr + 1) % int'(CCUGLB_MapWords);
        if (m_cnt < 4095) m_cnt++;
      end
      if (e_rd || e_wr) begin
        m_last_rd = e_rd;
        m_last_addr = e_addr;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    int first_acc, first_vld, nv, acc;
    logic [5:0] rseq, wseq;
    logic [11:0] wa [5];
    logic [11:0] exp_wa [5];
    exp_wa[0] = 12'h200; exp_wa[1] = 12'h201; exp_wa[2] = 12'h202;
    exp_wa[3] = 12'h200; exp_wa[4] = 12'h201;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = rnd256();
      ref_mem[i] = sram[i];
    end

    // Reset state
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(1, 1'b1);

    // 1: in-order reads, latency 2, 1 word/cycle
    CCUGLB_CrdBase = 12'h100;
    first_acc = -1; first_vld = -1; nv = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, i < 8, 10'(i), 1'b0, '0, 1'b1, 1'b0);
      if (g_ardy && first_acc < 0) first_acc = g_cyc;
      if (g_vld && first_vld < 0) first_vld = g_cyc;
      if (g_vld) nv++;
    end
    chk("t1_latency", 256'(first_vld - first_acc), 256'd2);
    chk("t1_words", 256'(nv), 256'd8);

    // 2: backpressure caps accepts at FIFO_DEPTH
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 10'(20 + i), 1'b0, '0, 1'b0, 1'b0);
      if (g_ardy) acc++;
    end
    chk("t2_accepts", 256'(acc), 256'd4);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 10'(40 + i), 1'b0, '0, 1'b1, 1'b0);
      if (g_ardy) acc++;
    end
    chk("t2_resume", 256'(acc > 0), 256'd1);
    idle(5, 1'b1);

    // 3: contested grants after reset start with RD
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    rseq = '0; wseq = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 10'(60 + i), 1'b1, rnd256(), 1'b1, 1'b0);
      rseq = {rseq[4:0], g_ardy};
      wseq = {wseq[4:0], g_mrdy};
    end
    chk("t3_rd_seq", rseq, 6'b101010);
    chk("t3_wr_seq", wseq, 6'b010101);
    idle(4, 1'b1);

    // 4: map pointer wraps at MapWords
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    CCUGLB_MapBase = 12'h200; CCUGLB_MapWords = 12'd3;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, rnd256(), 1'b1, 1'b0);
      wa[i] = g_mrdy ? g_addr : 12'hfff;
    end
    for (int i = 0; i < 5; i++) chk("t4_wr_addr", wa[i], exp_wa[i]);
    idle(1, 1'b1);
    chk("t4_wr_cnt", GLBCCU_MapWrCnt, 12'd5);

    // 5: Clr with 2 words stored and 1 in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'(80 + i), 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      if (g_vld) nv++;
    end
    chk("t5_no_stale", 256'(nv), 256'd0);
    step(1'b1, 1'b0, '0, 1'b1, rnd256(), 1'b1, 1'b0);
    chk("t5_map_base", g_addr, 12'h200);

    // 6: reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 10'($urandom), 1'b1, rnd256(), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_vld", g_vld, 1'b0);
    chk("t6_rdy", {g_ardy, g_mrdy}, 2'b00);
    chk("t6_cnt", GLBCCU_MapWrCnt, 12'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 10'(i), 1'b1, rnd256(), 1'b1, 1'b0);
    idle(4, 1'b1);

    // Randomized traffic
    CCUGLB_CrdBase = 12'($urandom); CCUGLB_MapBase = 12'($urandom);
    CCUGLB_MapWords = 12'($urandom_range(1, 8));
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++)
      step(1'b1, ($urandom % 4) != 0, 10'($urandom), ($urandom % 3) == 0, rnd256(),
           ($urandom % 3) != 0, ($urandom % 64) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
